ofdm_cp_remover: RTL

//  Receive-side counterpart of ofdm_frame_gen: takes the continuous baseband I/Q sample stream,

---
 rtl/ofdm_rx_pkg.sv | 29 ++
 rtl/ofdm_sample_fifo.sv | 67 ++++++
 rtl/ofdm_cp_remover.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_rx_pkg.sv
// Shared definitions for the OFDM receive cyclic-prefix remover: default geometry,
// FSM state encoding and width helpers.
package ofdm_rx_pkg;

    localparam int FFT_SIZE_DEF    = 256;
    localparam int CP_LEN_DEF      = 64;
    localparam int DATA_W_DEF      = 16;
    localparam int MEMORY_SYZE_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP_CP = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } rx_state_e;

    // Buffered word is {last, q, i}.
    function automatic int sample_word_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // Sample counter must index both the prefix and the useful part of a symbol.
    function automatic int samp_cnt_w(input int fft_size, input int cp_len);
        int m;
        m = (fft_size > cp_len) ? fft_size : cp_len;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ofdm_sample_fifo.sv
// Synchronous sample FIFO with a registered output stage. The output register counts
// toward capacity, so at most 2**AW words are held in total.
module ofdm_sample_fifo #(
    parameter int WIDTH = 33,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      mem_cnt_s;
    logic [AW+1:0]    occ_s;
    logic             pop_s;
    logic             push_s;
    logic             load_s;

    // Occupancy, accept and output-refill decisions.
    always_comb begin
        mem_cnt_s = wr_ptr_r - rd_ptr_r;
        occ_s     = {1'b0, mem_cnt_s} + {{(AW+1){1'b0}}, rd_valid};
        pop_s     = rd_valid & rd_ready;
        // A pop in the same cycle frees a slot, so the push is still taken.
        full      = (occ_s >= (AW+2)'(DEPTH)) && !pop_s;
        push_s    = wr_en && !full;
        load_s    = (mem_cnt_s != {(AW+1){1'b0}}) && (!rd_valid || pop_s);
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointers and registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            rd_valid <= 1'b0;
            rd_data  <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
                rd_valid <= 1'b1;
                rd_data  <= mem_r[rd_ptr_r[AW-1:0]];
            end else if (pop_s) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ofdm_cp_remover.sv
// Drops the cyclic prefix of each received OFDM symbol and buffers the useful samples
// for the RX FFT. Optional statistics outputs are enabled with OFDM_RX_STATS_EN.
module ofdm_cp_remover
    import ofdm_rx_pkg::*;
#(
    parameter int FFT_SIZE    = FFT_SIZE_DEF,
    parameter int CP_LEN      = CP_LEN_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEMORY_SYZE = MEMORY_SYZE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              beginRX,
    input  logic [7:0]        num_symbols,
    input  logic              valid,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [DATA_W-1:0] in_data_q,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data_i,
    output logic [DATA_W-1:0] out_data_q,
    output logic              out_last,
    output logic              busy,
    output logic              done_receive,
    output logic              overflow
`ifdef OFDM_RX_STATS_EN
    ,
    output logic [7:0]        sym_count,
    output logic [15:0]       drop_count
`endif
);

    localparam int CNT_W  = samp_cnt_w(FFT_SIZE, CP_LEN);
    localparam int WORD_W = sample_word_w(DATA_W);
    localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'(CP_LEN - 1);
    localparam logic [CNT_W-1:0] FFT_LAST = CNT_W'(FFT_SIZE - 1);

    rx_state_e         state_r;
    rx_state_e         state_next_s;
    logic [7:0]        num_sym_r;
    logic [7:0]        sym_cnt_r;
    logic [CNT_W-1:0]  samp_cnt_r;
    logic              overflow_r;
    logic              done_r;
    logic              busy_r;
    logic              sym_last_s;
    logic              wr_en_s;
    logic              last_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_valid_s;
    logic [WORD_W-1:0] fifo_rd_data_s;

    assign sym_last_s = (({1'b0, sym_cnt_r} + 9'd1) == {1'b0, num_sym_r});

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (beginRX) begin
                    if (num_symbols == 8'd0) begin
                        state_next_s = ST_DONE;
                    end else if (valid && (CP_LEN == 32'sd1)) begin
                        state_next_s = ST_COLLECT;
                    end else begin
                        state_next_s = ST_SKIP_CP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SKIP_CP: begin
                if (valid && (samp_cnt_r == CP_LAST)) begin
                    state_next_s = ST_COLLECT;
                end else begin
                    state_next_s = ST_SKIP_CP;
                end
            end
            ST_COLLECT: begin
                if (valid && (samp_cnt_r == FFT_LAST)) begin
                    state_next_s = sym_last_s ? ST_DONE : ST_SKIP_CP;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: buffer write strobe and symbol-end marker.
    always_comb begin
        wr_en_s = 1'b0;
        last_s  = 1'b0;
        if ((state_r == ST_COLLECT) && valid) begin
            wr_en_s = 1'b1;
            last_s  = (samp_cnt_r == FFT_LAST);
        end else begin
            wr_en_s = 1'b0;
            last_s  = 1'b0;
        end
    end

    assign drop_s = wr_en_s && fifo_full_s;

    // Frame and sample counters; they advance even when the sample is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_sym_r  <= 8'd0;
            sym_cnt_r  <= 8'd0;
            samp_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (beginRX) begin
                        num_sym_r  <= num_symbols;
                        sym_cnt_r  <= 8'd0;
                        samp_cnt_r <= (valid && (CP_LEN > 32'sd1)) ? CNT_W'(32'd1) : {CNT_W{1'b0}};
                    end
                end
                ST_SKIP_CP: begin
                    if (valid) begin
                        samp_cnt_r <= (samp_cnt_r == CP_LAST) ? {CNT_W{1'b0}} : samp_cnt_r + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (valid) begin
                        if (samp_cnt_r == FFT_LAST) begin
                            samp_cnt_r <= {CNT_W{1'b0}};
                            sym_cnt_r  <= sym_cnt_r + 8'd1;
                        end else begin
                            samp_cnt_r <= samp_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    samp_cnt_r <= samp_cnt_r;
                end
            endcase
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            overflow_r <= overflow_r | drop_s;
            done_r     <= (state_r == ST_DONE);
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    ofdm_sample_fifo #(
        .WIDTH (WORD_W),
        .AW    (MEMORY_SYZE)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en_s),
        .wr_data  ({last_s, in_data_q, in_data_i}),
        .full     (fifo_full_s),
        .rd_ready (out_ready),
        .rd_valid (fifo_valid_s),
        .rd_data  (fifo_rd_data_s)
    );

    assign out_valid    = fifo_valid_s;
    assign out_data_i   = fifo_rd_data_s[DATA_W-1:0];
    assign out_data_q   = fifo_rd_data_s[2*DATA_W-1:DATA_W];
    assign out_last     = fifo_rd_data_s[2*DATA_W];
    assign busy         = busy_r;
    assign done_receive = done_r;
    assign overflow     = overflow_r;

`ifdef OFDM_RX_STATS_EN
    logic [7:0]  sym_count_r;
    logic [15:0] drop_count_r;

    // Per-frame completed-symbol count and saturating drop count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_count_r  <= 8'd0;
            drop_count_r <= 16'd0;
        end else begin
            if ((state_r == ST_IDLE) && beginRX) begin
                sym_count_r <= 8'd0;
            end else if (wr_en_s && last_s) begin
                sym_count_r <= sym_count_r + 8'd1;
            end
            if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign sym_count  = sym_count_r;
    assign drop_count = drop_count_r;
`endif

endmodule
